operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Read-side counterpart to the ALU writeback path into the register file.
- Accepts decoded instructions (rs1, rs2, rd, imm) over a valid/ready handshake and drives the register file read ports.
- Forwards same-cycle writeback data, tracks outstanding writes with a per-register scoreboard, and stalls on hazards.
- Presents registered operands (src1, src2, imm, rd) to the ALU one cycle after acceptance.

Parameters:
- XLEN, 32, data width of registers, immediate and operands.
- NR_REG, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width; must equal clog2(NR_REG).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  instruction accepted this cycle when high together with in_valid.
- in_rs1  input  ADDR_W  source register 1.
- in_rs2  input  ADDR_W  source register 2.
- in_rd  input  ADDR_W  destination register.
- in_rd_wen  input  1  instruction writes rd.
- in_imm  input  XLEN  immediate.
- rf_raddr1  output  ADDR_W  register file read address 1; combinationally equal to in_rs1.
- rf_raddr2  output  ADDR_W  register file read address 2; combinationally equal to in_rs2.
- rf_rdata1  input  XLEN  combinational read data 1.
- rf_rdata2  input  XLEN  combinational read data 2.
- wb_wen  input  1  writeback strobe (same signals that drive the register file write port).
- wb_waddr  input  ADDR_W  writeback address.
- wb_wdata  input  XLEN  writeback data.
- out_valid  output  1  operand bundle valid.
- out_ready  input  1  ALU consumes bundle.
- out_src1  output  XLEN  operand 1.
- out_src2  output  XLEN  operand 2.
- out_imm  output  XLEN  immediate.
- out_rd  output  ADDR_W  destination register.
- out_rd_wen  output  1  destination write enable.
- sb_busy  output  NR_REG  scoreboard bits, for debug and verification.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; out_src1, out_src2, out_imm, out_rd, out_rd_wen = 0; sb_busy = 0.
  - Reset mid-operation drops any held bundle and clears every busy bit immediately, without waiting for a clock edge.
- Operand select, per source s in {rs1, rs2}:
  - s==0 gives 0.
  - Otherwise, if wb_wen and wb_waddr==s, gives wb_wdata (forwarding).
  - Otherwise gives rf_rdata.
- Hazard, per source:
  - Hazard when s!=0, busy[s]=1, and NOT (wb_wen and wb_waddr==s).
  - WAW hazard: in_rd_wen, in_rd!=0, busy[in_rd]=1, and not being cleared this cycle.
- Handshake:
  - space = !out_valid | out_ready.
  - in_ready = space & no hazard; it is combinational in the in_* addresses and wb_*.
  - accept = in_valid & in_ready.
- Output register:
  - On accept: load the bundle and set out_valid=1. Latency from accept to out_valid is exactly 1 cycle.
  - Else if out_ready: out_valid=0.
  - Else: hold all out_* unchanged (stable while stalled).
  - Full-throughput back-to-back issue with out_ready=1: one instruction per cycle.
- Scoreboard:
  - wb_wen with wb_waddr!=0 clears busy[wb_waddr].
  - accept with in_rd_wen and in_rd!=0 sets busy[in_rd].
  - Same register set and cleared in one cycle: set wins.
  - busy[0] is always 0.
  - wb_wen with wb_waddr==0 has no effect.
  - Clearing a non-busy register is harmless.
- Held-bundle staleness cannot occur. Every producer of a held bundle's sources had completed before issue, and later producers cannot issue ahead of the held bundle.

Decomposition:
- Shared package (e.g. npc_pkg):
  - XLEN, NR_REG, ADDR_W constants.
  - Typedef for the operand bundle struct {src1, src2, imm, rd, rd_wen}.
- Sub-module scoreboard:
  - Busy-bit array with set/clear ports and a hazard query for three addresses.
  - This is the natural split.
- The forwarding muxes and the output register stay in operand_fetch.

Test Plan:
- Reset, then issue rs1=1, rs2=2 with rf_rdata1=0x11, rf_rdata2=0x22, imm=4, rd=3 -> next cycle out_valid=1, src1=0x11, src2=0x22, imm=4, rd=3; sb_busy[3]=1.
- rs1=0 with rf_rdata1=0xDEAD -> out_src1=0.
- rs1=3 while busy[3] and no writeback -> in_ready=0 and out_valid falls after the consumer takes the previous bundle. Then wb_wen=1, wb_waddr=3, wb_wdata=0x55 -> in_ready=1 the same cycle, out_src1=0x55 next cycle, busy[3]=0.
- out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and out_* stable. Then out_ready=1 -> new bundle appears the following cycle.
- Same cycle: accept rd=5 and wb_waddr=5 -> busy[5]=1 afterwards (set wins). A following instruction writing rd=5 stalls until the next wb to 5.
- Assert rst_n=0 asynchronously between clock edges while out_valid=1 and busy[7]=1 -> out_valid=0 and sb_busy=0 before the next clk edge.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared constants, the operand bundle type and the source-forwarding helper
// for the operand fetch stage.
package operand_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NR_REG = 32;
  localparam int unsigned ADDR_W = $clog2(NR_REG);

  typedef struct packed {
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   imm;
    logic [ADDR_W-1:0] rd;
    logic              rd_wen;
  } bundle_t;

  // x0 reads zero; a same-cycle writeback overrides the stale register file value
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic              wb_wen,
    input logic [ADDR_W-1:0] wb_waddr,
    input logic [XLEN-1:0]   wb_wdata,
    input logic [XLEN-1:0]   rf_rdata
  );
    logic [XLEN-1:0] res;
    res = rf_rdata;
    if (addr == ADDR_W'(0)) begin
      res = XLEN'(0);
    end else if (wb_wen && (wb_waddr == addr)) begin
      res = wb_wdata;
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits for writes in flight, with hazard queries that
// treat a register being written back this cycle as already free.
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] qa_addr,
  input  logic [ADDR_W-1:0] qb_addr,
  input  logic [ADDR_W-1:0] qc_addr,
  output logic              qa_hz_c,
  output logic              qb_hz_c,
  output logic              qc_hz_c,
  output logic [NR_REG-1:0] busy
);

  logic [NR_REG-1:0] busy_q;
  logic [NR_REG-1:0] busy_d;

  function automatic logic hz(input logic [ADDR_W-1:0] a,
                              input logic [NR_REG-1:0] bq,
                              input logic              ce,
                              input logic [ADDR_W-1:0] ca);
    return (a != ADDR_W'(0)) && bq[a] && !(ce && (ca == a));
  endfunction

  always_comb begin
    qa_hz_c = hz(qa_addr, busy_q, clr_en, clr_addr);
    qb_hz_c = hz(qb_addr, busy_q, clr_en, clr_addr);
    qc_hz_c = hz(qc_addr, busy_q, clr_en, clr_addr);
  end

  // Clear first so a same-cycle set of the same register wins
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register file, forwards writeback data, stalls on
// scoreboard hazards and presents a registered operand bundle to the ALU.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_wen,
  input  logic [XLEN-1:0]   in_imm,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [XLEN-1:0]   wb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_src1,
  output logic [XLEN-1:0]   out_src2,
  output logic [XLEN-1:0]   out_imm,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_wen,
  output logic [NR_REG-1:0] sb_busy
);

  logic    valid_q;
  logic    valid_d;
  bundle_t bundle_q;
  bundle_t bundle_d;

  logic hz_rs1_c;
  logic hz_rs2_c;
  logic hz_rd_c;
  logic hazard_c;
  logic space_c;
  logic accept_c;
  logic set_en_c;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  operand_fetch_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en_c),
    .set_addr (in_rd),
    .clr_en   (wb_wen),
    .clr_addr (wb_waddr),
    .qa_addr  (in_rs1),
    .qb_addr  (in_rs2),
    .qc_addr  (in_rd),
    .qa_hz_c  (hz_rs1_c),
    .qb_hz_c  (hz_rs2_c),
    .qc_hz_c  (hz_rd_c),
    .busy     (sb_busy)
  );

  // Handshake: free slot and no RAW/WAW hazard
  always_comb begin
    hazard_c = hz_rs1_c || hz_rs2_c || (in_rd_wen && hz_rd_c);
    space_c  = !valid_q || out_ready;
    in_ready = space_c && !hazard_c;
    accept_c = in_valid && in_ready;
    set_en_c = accept_c && in_rd_wen && (in_rd != ADDR_W'(0));
  end

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (accept_c) begin
      valid_d         = 1'b1;
      bundle_d.src1   = fwd_sel(in_rs1, wb_wen, wb_waddr, wb_wdata, rf_rdata1);
      bundle_d.src2   = fwd_sel(in_rs2, wb_wen, wb_waddr, wb_wdata, rf_rdata2);
      bundle_d.imm    = in_imm;
      bundle_d.rd     = in_rd;
      bundle_d.rd_wen = in_rd_wen;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_src1   = bundle_q.src1;
  assign out_src2   = bundle_q.src2;
  assign out_imm    = bundle_q.imm;
  assign out_rd     = bundle_q.rd;
  assign out_rd_wen = bundle_q.rd_wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic              in_rd_wen;
  logic [31:0]       in_imm;
  logic [4:0]        rf_raddr1, rf_raddr2;
  logic [31:0]       rf_rdata1, rf_rdata2;
  logic              wb_wen;
  logic [4:0]        wb_waddr;
  logic [31:0]       wb_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_src1, out_src2, out_imm;
  logic [4:0]        out_rd;
  logic              out_rd_wen;
  logic [31:0]       sb_busy;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_imm(in_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .sb_busy(sb_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: architectural register file, busy set, held bundle
  logic [31:0] rf [32];
  logic [31:0] m_busy;
  bit          m_valid;
  logic [31:0] m_src1, m_src2, m_imm;
  logic [4:0]  m_rd;
  logic        m_rd_wen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] operand(input logic [4:0] s, input logic [31:0] rdata);
    if (s == 5'd0) return 32'd0;
    if (wb_wen && wb_waddr == s) return wb_wdata;
    return rdata;
  endfunction

  function automatic bit blocked(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(wb_wen && wb_waddr == r);
  endfunction

  function automatic bit exp_ready();
    return (!m_valid || out_ready) && !blocked(in_rs1) && !blocked(in_rs2)
           && !(in_rd_wen && blocked(in_rd));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busy = '0;
    m_src1 = '0; m_src2 = '0; m_imm = '0; m_rd = '0; m_rd_wen = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit wen, input logic [31:0] imm,
                       input bit ordy, input bit wbe, input logic [4:0] wba,
                       input logic [31:0] wbd);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen; in_imm = imm;
    out_ready = ordy; wb_wen = wbe; wb_waddr = wba; wb_wdata = wbd;
    rf_rdata1 = (rs1 == 5'd0) ? 32'hDEAD : rf[rs1];
    rf_rdata2 = (rs2 == 5'd0) ? 32'hBEEF : rf[rs2];
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic step();
    bit          e_rdy, acc, wbe_cap;
    logic [4:0]  wba_cap;
    logic [31:0] wbd_cap;
    rf_rdata1 = (in_rs1 == 5'd0) ? 32'hDEAD : rf[in_rs1];
    rf_rdata2 = (in_rs2 == 5'd0) ? 32'hBEEF : rf[in_rs2];
    #1;
    e_rdy = exp_ready();
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("rf_raddr1", 32'(rf_raddr1), 32'(in_rs1));
    chk("rf_raddr2", 32'(rf_raddr2), 32'(in_rs2));
    acc = in_valid && e_rdy;
    if (acc) begin
      m_valid = 1; m_src1 = operand(in_rs1, rf_rdata1); m_src2 = operand(in_rs2, rf_rdata2);
      m_imm = in_imm; m_rd = in_rd; m_rd_wen = in_rd_wen;
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (wb_wen && wb_waddr != 5'd0) m_busy[wb_waddr] = 1'b0;
    if (acc && in_rd_wen && in_rd != 5'd0) m_busy[in_rd] = 1'b1;
    wbe_cap = wb_wen; wba_cap = wb_waddr; wbd_cap = wb_wdata;
    @(posedge clk); #1;
    if (wbe_cap && wba_cap != 5'd0) rf[wba_cap] = wbd_cap;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("sb_busy", sb_busy, m_busy);
    if (m_valid) begin
      chk("out_src1", out_src1, m_src1);
      chk("out_src2", out_src2, m_src2);
      chk("out_imm", out_imm, m_imm);
      chk("out_rd", 32'(out_rd), 32'(m_rd));
      chk("out_rd_wen", 32'(out_rd_wen), 32'(m_rd_wen));
    end
  endtask

  initial begin
    logic [31:0] held;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd0; rf[1] = 32'h11; rf[2] = 32'h22;
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sb_busy", sb_busy, 32'd0);
    chk("rst_out_src1", out_src1, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First issue: registered one cycle later, rd marked busy
    drive(1, 5'd1, 5'd2, 5'd3, 1, 32'd4, 1, 0, 0, 0);
    step();
    chk("lit_valid", 32'(out_valid), 32'd1);
    chk("lit_src1", out_src1, 32'h11);
    chk("lit_src2", out_src2, 32'h22);
    chk("lit_imm", out_imm, 32'd4);
    chk("lit_rd", 32'(out_rd), 32'd3);
    chk("lit_busy3", 32'(sb_busy[3]), 32'd1);

    // x0 source reads zero despite garbage read data
    drive(1, 5'd0, 5'd2, 5'd0, 0, 32'd8, 1, 0, 0, 0);
    step();
    chk("lit_x0", out_src1, 32'd0);

    // RAW on busy x3, then released by same-cycle writeback with forwarding
    drive(1, 5'd3, 5'd0, 5'd0, 0, 32'd12, 1, 0, 0, 0);
    #1 chk("lit_raw_stall", 32'(in_ready), 32'd0);
    step();
    chk("lit_valid_fall", 32'(out_valid), 32'd0);
    drive(1, 5'd3, 5'd0, 5'd0, 0, 32'd12, 1, 1, 5'd3, 32'h55);
    #1 chk("lit_fwd_ready", 32'(in_ready), 32'd1);
    step();
    chk("lit_fwd_src1", out_src1, 32'h55);
    chk("lit_busy3_clr", 32'(sb_busy[3]), 32'd0);

    // Consumer stall: bundle held stable for three cycles
    drive(1, 5'd1, 5'd2, 5'd0, 0, 32'h100, 1, 0, 0, 0);
    step();
    held = out_src1;
    drive(1, 5'd1, 5'd2, 5'd0, 0, 32'h200, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("lit_stall_ready", 32'(in_ready), 32'd0);
      step();
      chk("lit_stall_imm", out_imm, 32'h100);
      chk("lit_stall_src1", out_src1, held);
    end
    drive(1, 5'd1, 5'd2, 5'd0, 0, 32'h200, 1, 0, 0, 0);
    step();
    chk("lit_resume_imm", out_imm, 32'h200);

    // Set wins over same-cycle clear; WAW stall until the next writeback
    drive(1, 5'd0, 5'd0, 5'd5, 1, 32'd0, 1, 1, 5'd5, 32'h77);
    step();
    chk("lit_set_wins", 32'(sb_busy[5]), 32'd1);
    drive(1, 5'd0, 5'd0, 5'd5, 1, 32'd0, 1, 0, 0, 0);
    #1 chk("lit_waw_stall", 32'(in_ready), 32'd0);
    step();
    drive(1, 5'd0, 5'd0, 5'd5, 1, 32'd0, 1, 1, 5'd5, 32'h99);
    #1 chk("lit_waw_release", 32'(in_ready), 32'd1);
    step();
    chk("lit_busy5_again", 32'(sb_busy[5]), 32'd1);

    // Asynchronous reset between edges while a bundle is held
    drive(1, 5'd0, 5'd0, 5'd7, 1, 32'd7, 1, 0, 0, 0);
    step();
    chk("lit_busy7", 32'(sb_busy[7]), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_valid", 32'(out_valid), 32'd0);
    chk("lit_async_busy", sb_busy, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wba;
      bit         wbe;
      wbe = ($urandom_range(0, 1) == 1);
      wba = 5'($urandom_range(0, 7));
      if (m_busy != 0 && $urandom_range(0, 3) != 0) begin
        int k;
        k = $urandom_range(0, 31);
        for (int j = 0; j < 32; j++) begin
          if (m_busy[(k + j) % 32]) begin
            wba = 5'((k + j) % 32);
            break;
          end
        end
      end
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 3) != 0, wbe, wba, $urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
